// File: rtl/johnson_pkg.sv
// Shared constants for the 4-bit-to-5-bit Johnson code: codeword table,
// digit markers and the output-stage state type.
package johnson_pkg;

  localparam logic [4:0] JOHNSON_CODE [0:9] = '{
    5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
    5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001
  };

  localparam logic [3:0] DIGIT_INVALID = 4'hF;
  localparam logic [3:0] DIGIT_MAX     = 4'd9;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Successor in the decimal ring 0..9.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/johnson_lut.sv
// Combinational Johnson codeword to decimal digit lookup with legality flag.
module johnson_lut
  import johnson_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = DIGIT_INVALID;
    legal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (code == JOHNSON_CODE[i]) begin
        digit = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decodificador.sv
// Johnson-code decoder: one-entry registered output stage with illegal-code
// and sequence checking plus saturating error counters.
module decodificador
  import johnson_pkg::*;
#(
  parameter bit SEQ_CHECK = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       in_code,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_digit,
  output logic             out_code_err,
  output logic             out_seq_err,
  output logic [CNT_W-1:0] code_err_cnt,
  output logic [CNT_W-1:0] seq_err_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             code_err_q, code_err_d;
  logic             seq_err_q, seq_err_d;
  logic [3:0]       prev_digit_q, prev_digit_d;
  logic             have_prev_q, have_prev_d;
  logic [CNT_W-1:0] code_cnt_q, code_cnt_d;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;

  logic [3:0] lut_digit;
  logic       lut_legal;
  logic       in_xfer, out_xfer, seq_err_now;

  johnson_lut u_lut (
    .code  (in_code),
    .digit (lut_digit),
    .legal (lut_legal)
  );

  assign out_valid = (state_q == ST_FULL);
  // Reset forces ready high so the block presents itself as EMPTY.
  assign in_ready  = reset | ~out_valid | out_ready;
  assign in_xfer   = in_valid & in_ready & ~reset;
  assign out_xfer  = out_valid & out_ready;

  assign seq_err_now = SEQ_CHECK & have_prev_q & lut_legal &
                       (lut_digit != next_digit(prev_digit_q));

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    code_err_d   = code_err_q;
    seq_err_d    = seq_err_q;
    prev_digit_d = prev_digit_q;
    have_prev_d  = have_prev_q;
    code_cnt_d   = code_cnt_q;
    seq_cnt_d    = seq_cnt_q;
    if (in_xfer) begin
      state_d    = ST_FULL;
      digit_d    = lut_digit;
      code_err_d = ~lut_legal;
      seq_err_d  = seq_err_now;
      if (lut_legal) begin
        prev_digit_d = lut_digit;
        have_prev_d  = 1'b1;
      end
      if (!lut_legal) code_cnt_d = sat_inc(code_cnt_q);
      if (seq_err_now) seq_cnt_d = sat_inc(seq_cnt_q);
    end else if (out_xfer) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      digit_q      <= 4'd0;
      code_err_q   <= 1'b0;
      seq_err_q    <= 1'b0;
      prev_digit_q <= 4'd0;
      have_prev_q  <= 1'b0;
      code_cnt_q   <= '0;
      seq_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      code_err_q   <= code_err_d;
      seq_err_q    <= seq_err_d;
      prev_digit_q <= prev_digit_d;
      have_prev_q  <= have_prev_d;
      code_cnt_q   <= code_cnt_d;
      seq_cnt_q    <= seq_cnt_d;
    end
  end

  assign out_digit    = digit_q;
  assign out_code_err = code_err_q;
  assign out_seq_err  = seq_err_q;
  assign code_err_cnt = code_cnt_q;
  assign seq_err_cnt  = seq_cnt_q;

endmodule

// File: tb/tb_decodificador.sv
// Scoreboard bench for decodificador: randomized and directed codewords
// checked against a digit-ring model; second instance has CNT_W=2, no seq check.
module tb_decodificador;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [4:0] in_code = 5'd0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_code_err, out_seq_err;
  logic [3:0] out_digit;
  logic [7:0] code_err_cnt, seq_err_cnt;

  logic       s_in_ready, s_out_valid, s_out_code_err, s_out_seq_err;
  logic [3:0] s_out_digit;
  logic [1:0] s_code_err_cnt, s_seq_err_cnt;

  decodificador #(.SEQ_CHECK(1'b1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_digit(out_digit), .out_code_err(out_code_err), .out_seq_err(out_seq_err),
    .code_err_cnt(code_err_cnt), .seq_err_cnt(seq_err_cnt)
  );

  decodificador #(.SEQ_CHECK(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_digit(s_out_digit), .out_code_err(s_out_code_err), .out_seq_err(s_out_seq_err),
    .code_err_cnt(s_code_err_cnt), .seq_err_cnt(s_seq_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int digit;
    int cerr;
    int serr;
    int ccnt;
    int scnt;
    int ccnt2;
  } item_t;

  item_t q[$];
  int    tests = 0;
  int    fails = 0;
  bit    exp_full = 1'b0;

  // Reference model state.
  int jc[10] = '{0, 16, 24, 28, 30, 31, 15, 7, 3, 1};
  int m_prev, m_have, m_ccnt, m_scnt, m_ccnt2;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_have = 0; m_ccnt = 0; m_scnt = 0; m_ccnt2 = 0;
  endtask

  function automatic item_t model_accept(input int code);
    item_t it;
    int d;
    d = -1;
    for (int i = 0; i < 10; i++) if (jc[i] == code) d = i;
    if (d < 0) begin
      it.digit = 15; it.cerr = 1; it.serr = 0;
      if (m_ccnt < 255) m_ccnt++;
      if (m_ccnt2 < 3) m_ccnt2++;
    end else begin
      it.digit = d; it.cerr = 0;
      it.serr = (m_have != 0 && d != (m_prev + 1) % 10) ? 1 : 0;
      if (it.serr != 0 && m_scnt < 255) m_scnt++;
      m_prev = d; m_have = 1;
    end
    it.ccnt = m_ccnt; it.scnt = m_scnt; it.ccnt2 = m_ccnt2;
    return it;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit v, input int code, input bit ordy);
    bit xin, xout;
    in_valid = v; in_code = 5'(code); out_ready = ordy;
    #1;
    check("in_ready", int'(in_ready), int'(!exp_full || ordy));
    xin  = v && (!exp_full || ordy);
    xout = exp_full && ordy;
    if (xin) q.push_back(model_accept(code));
    @(posedge clk); #1;
    exp_full = xin || (exp_full && !xout);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; in_code = 5'($urandom_range(0, 31));
    out_ready = 1'($urandom_range(0, 1));
    #1;
    check("in_ready_rst", int'(in_ready), 1);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete(); model_reset(); exp_full = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_digit", int'(out_digit), 0);
    check("rst_code_err", int'(out_code_err), 0);
    check("rst_seq_err", int'(out_seq_err), 0);
    check("rst_code_cnt", int'(code_err_cnt), 0);
    check("rst_seq_cnt", int'(seq_err_cnt), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: compares the held result against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      check("out_valid", int'(out_valid), int'(exp_full));
      check("sat_out_valid", int'(s_out_valid), int'(exp_full));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("scoreboard_nonempty", 0, 1);
        end else begin
          check("out_digit", int'(out_digit), q[0].digit);
          check("out_code_err", int'(out_code_err), q[0].cerr);
          check("out_seq_err", int'(out_seq_err), q[0].serr);
          check("code_err_cnt", int'(code_err_cnt), q[0].ccnt);
          check("seq_err_cnt", int'(seq_err_cnt), q[0].scnt);
          check("sat_out_digit", int'(s_out_digit), q[0].digit);
          check("sat_seq_err", int'(s_out_seq_err), 0);
          check("sat_code_cnt", int'(s_code_err_cnt), q[0].ccnt2);
          check("sat_seq_cnt", int'(s_seq_err_cnt), 0);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Full ring 0..9,0 at full throughput.
    for (int i = 0; i < 11; i++) step(1'b1, jc[i % 10], 1'b1);
    step(1'b0, 0, 1'b1);

    // Exhaustive sweep from a clean state.
    do_reset();
    for (int c = 0; c < 32; c++) step(1'b1, c, 1'b1);
    step(1'b0, 0, 1'b1);
    @(negedge clk);
    check("sweep_code_cnt", int'(code_err_cnt), 22);
    check("sweep_sat_cnt", int'(s_code_err_cnt), 3);
    @(posedge clk); #1;

    // 2, 5, 6: only the jump to 5 is a sequence error.
    do_reset();
    step(1'b1, 5'b11000, 1'b1);
    step(1'b1, 5'b11111, 1'b1);
    step(1'b1, 5'b01111, 1'b1);
    step(1'b0, 0, 1'b1);
    @(negedge clk);
    check("seq_cnt_after_256", int'(seq_err_cnt), 1);
    @(posedge clk); #1;

    // Stall while FULL, then accept on the cycle out_ready rises.
    step(1'b1, jc[7], 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, jc[8], 1'b0);
    step(1'b1, jc[8], 1'b1);
    step(1'b0, 0, 1'b1);

    // Reset while FULL with a pending codeword.
    step(1'b1, jc[3], 1'b0);
    do_reset();
    step(1'b1, jc[6], 1'b1);
    step(1'b0, 0, 1'b1);

    // Randomized traffic, biased toward legal codewords in order.
    for (int i = 0; i < 400; i++) begin
      int code;
      if ($urandom_range(0, 3) == 0) code = $urandom_range(0, 31);
      else if ($urandom_range(0, 3) == 0) code = jc[$urandom_range(0, 9)];
      else code = jc[(m_prev + 1) % 10];
      step(1'($urandom_range(0, 3) != 0), code, 1'($urandom_range(0, 2) != 0));
    end
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
